// File: rtl/program_counter.sv
// program_counter -- fetch-address generator with BOOT/RUN/HALT control.
//
// Ports:
//   clk              single clock, rising-edge
//   rst              synchronous active-high reset (forces BOOT)
//   stall            hold pc, state and retired_count for the cycle
//   next_pc_src      00 = pc+4, 01 = pc+imm, 10 = (rs1_data+imm)&~1, 11 = pc+4
//   imm              sign-extended immediate from decode
//   rs1_data         rs1 value used by JALR
//   halt_req         ECALL/EBREAK in the current instruction
//   pc               current fetch address
//   pc_plus4         combinational pc+4 (link value)
//   fetch_valid      instruction at pc executes this cycle (RUN only)
//   halted           high in HALT
//   misaligned_fault sticky flag: a selected target was not word aligned
//   retired_count    number of completed instructions (wraps silently)
module program_counter #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  next_pc_src,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        misaligned_fault,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] count_nxt;
  logic        fault_nxt;
  logic [31:0] target;
  logic        target_misaligned;

  assign pc_plus4 = pc + 32'd4;

  // Target selection; JALR clears bit0 so only bit1 can fault there.
  always_comb begin
    target = pc_plus4;
    unique case (next_pc_src)
      2'b01:   target = pc + imm;
      2'b10:   target = (rs1_data + imm) & 32'hFFFF_FFFE;
      default: target = pc_plus4;
    endcase
  end

  assign target_misaligned = (target[1:0] != 2'b00);

  // State and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= BOOT;
      pc               <= RESET_PC;
      retired_count    <= '0;
      misaligned_fault <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      retired_count    <= count_nxt;
      misaligned_fault <= fault_nxt;
    end
  end

  // Next-state logic: in RUN, priority is stall > halt_req > misaligned > advance.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = retired_count;
    fault_nxt = misaligned_fault;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (stall) begin
          state_nxt = RUN;
        end else if (halt_req) begin
          state_nxt = HALT;
          count_nxt = retired_count + 32'd1;
        end else if (target_misaligned) begin
          state_nxt = HALT;
          fault_nxt = 1'b1;
        end else begin
          pc_nxt    = target;
          count_nxt = retired_count + 32'd1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    fetch_valid = 1'b0;
    halted      = 1'b0;
    unique case (state)
      RUN:     fetch_valid = 1'b1;
      HALT:    halted      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  next_pc_src = 2'b00;
  logic [31:0] imm = '0;
  logic [31:0] rs1_data = '0;
  logic        halt_req = 1'b0;

  logic [31:0] pc, pc_plus4, retired_count;
  logic        fetch_valid, halted, misaligned_fault;
  logic [31:0] pc2, pc_plus4_2, retired_count2;
  logic        fetch_valid2, halted2, misaligned_fault2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  program_counter #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .next_pc_src(next_pc_src),
    .imm(imm), .rs1_data(rs1_data), .halt_req(halt_req),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .halted(halted), .misaligned_fault(misaligned_fault),
    .retired_count(retired_count)
  );

  program_counter #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
    .clk(clk), .rst(rst), .stall(stall), .next_pc_src(next_pc_src),
    .imm(imm), .rs1_data(rs1_data), .halt_req(halt_req),
    .pc(pc2), .pc_plus4(pc_plus4_2), .fetch_valid(fetch_valid2),
    .halted(halted2), .misaligned_fault(misaligned_fault2),
    .retired_count(retired_count2)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        halt;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    logic        e_fv;
    logic        e_h;
    logic        e_f;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic [1:0] src, logic [31:0] im,
                              logic [31:0] rs1, logic h, logic [31:0] e_pc,
                              logic [31:0] e_cnt, logic e_fv, logic e_h, logic e_f);
    vec_t v;
    v.rst = r; v.stall = s; v.src = src; v.imm = im; v.rs1 = rs1; v.halt = h;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_fv = e_fv; v.e_h = e_h; v.e_f = e_f;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [1:0] src,
                       input logic [31:0] im, input logic [31:0] rs1, input logic h);
    @(negedge clk);
    rst = r; stall = s; next_pc_src = src; imm = im; rs1_data = rs1; halt_req = h;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_cnt,
                           input logic e_fv, input logic e_h, input logic e_f);
    check32({tag, " pc"}, pc, e_pc);
    check32({tag, " pc_plus4"}, pc_plus4, e_pc + 32'd4);
    check32({tag, " retired_count"}, retired_count, e_cnt);
    check32({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
    check32({tag, " halted"}, {31'd0, halted}, {31'd0, e_h});
    check32({tag, " misaligned_fault"}, {31'd0, misaligned_fault}, {31'd0, e_f});
  endtask

  initial begin
    // rst stall src imm rs1 halt | pc cnt fv h f   (state after the edge)
    vecs.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 32'h00,0, 0,0,0)); // BOOT
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h00,0, 1,0,0)); // RUN pc0
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h04,1, 1,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h08,2, 1,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h0C,3, 1,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h10,4, 1,0,0));
    vecs.push_back(mk(0,0,2'b01,32'h10,32'h0,0, 32'h20,5, 1,0,0));        // 0x10+0x10
    vecs.push_back(mk(0,0,2'b01,32'hFFFF_FFE8,32'h0,0, 32'h08,6, 1,0,0)); // back to 8
    vecs.push_back(mk(0,0,2'b01,32'hFFFF_FFF8,32'h0,0, 32'h00,7, 1,0,0)); // 8-8
    vecs.push_back(mk(0,0,2'b10,32'h3,32'h21,0, 32'h24,8, 1,0,0));        // JALR aligned
    vecs.push_back(mk(0,0,2'b11,32'h7,32'h0,0, 32'h28,9, 1,0,0));         // reserved = +4
    vecs.push_back(mk(0,1,2'b01,32'h5,32'h0,1, 32'h28,9, 1,0,0));         // stall x3
    vecs.push_back(mk(0,1,2'b01,32'h5,32'h0,1, 32'h28,9, 1,0,0));
    vecs.push_back(mk(0,1,2'b01,32'h5,32'h0,1, 32'h28,9, 1,0,0));
    vecs.push_back(mk(0,0,2'b01,32'h5,32'h0,1, 32'h28,10, 0,1,0));        // halt counts
    vecs.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 32'h00,0, 0,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h00,0, 1,0,0));
    vecs.push_back(mk(0,0,2'b10,32'h2,32'h105,0, 32'h00,0, 0,1,1));       // JALR 0x106 faults
    vecs.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 32'h00,0, 0,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h00,0, 1,0,0));
    vecs.push_back(mk(0,0,2'b10,32'h0,32'h103,0, 32'h00,0, 0,1,1));       // JALR 0x102 faults
    vecs.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 32'h00,0, 0,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h00,0, 1,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h04,1, 1,0,0));
    vecs.push_back(mk(0,0,2'b01,32'h6,32'h0,0, 32'h04,1, 0,1,1));         // branch 0xA faults
    vecs.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 32'h00,0, 0,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h00,0, 1,0,0));
    vecs.push_back(mk(0,0,2'b01,32'h2,32'h0,1, 32'h00,1, 0,1,0));         // halt beats misalign
    vecs.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 32'h00,0, 0,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h00,0, 1,0,0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h04,1, 1,0,0));
    vecs.push_back(mk(1,1,2'b01,32'h8,32'h0,1, 32'h00,0, 0,0,0));         // rst beats stall/halt
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 32'h00,0, 1,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].src, vecs[i].imm, vecs[i].rs1, vecs[i].halt);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_cnt,
                vecs[i].e_fv, vecs[i].e_h, vecs[i].e_f);
    end

    // HALT is absorbing: reach pc=8/count=2 then fault on a misaligned branch.
    drive(0,0,2'b00,32'h0,32'h0,0);
    drive(0,0,2'b00,32'h0,32'h0,0);
    check_all("pre_halt", 32'h08, 2, 1, 0, 0);
    drive(0,0,2'b01,32'h1,32'h0,0);
    check_all("halt_entry", 32'h08, 2, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom), 2'($urandom), $urandom, $urandom, 1'($urandom));
      check_all($sformatf("halt_frozen%0d", i), 32'h08, 2, 0, 1, 1);
    end
    drive(1,0,2'b00,32'h0,32'h0,0);
    check_all("halt_reset", 32'h00, 0, 0, 0, 0);

    // Top-of-address-space wrap on the RESET_PC=FFFF_FFFC instance.
    check32("wrap boot pc", pc2, 32'hFFFF_FFFC);
    check32("wrap boot fetch_valid", {31'd0, fetch_valid2}, 32'd0);
    check32("wrap pc_plus4", pc_plus4_2, 32'h0000_0000);
    drive(0,0,2'b00,32'h0,32'h0,0);
    check32("wrap run pc", pc2, 32'hFFFF_FFFC);
    check32("wrap run fetch_valid", {31'd0, fetch_valid2}, 32'd1);
    drive(0,0,2'b00,32'h0,32'h0,0);
    check32("wrap next pc", pc2, 32'h0000_0000);
    check32("wrap fault", {31'd0, misaligned_fault2}, 32'd0);
    check32("wrap halted", {31'd0, halted2}, 32'd0);
    check32("wrap count", retired_count2, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port stall, input, 1, which holds the current PC and suppresses all updates for the cycle.
REQ-005 SHALL have port next_pc_src, input, 2, next-PC select: 00 = PC+4, 01 = PC+imm (branch/JAL), 10 = (rs1_data+imm) & ~1 (JALR), 11 = reserved, treated as 00.
REQ-006 SHALL have port imm, input, 32, sign-extended immediate from decode.
REQ-007 SHALL have port rs1_data, input, 32, register-file rs1 value for JALR.
REQ-008 SHALL have port halt_req, input, 1, ECALL/EBREAK decoded in the current instruction.
REQ-009 SHALL have port pc, output, 32, the current fetch address driving the instruction memory address input.
REQ-010 SHALL have port pc_plus4, output, 32, combinational pc+4, the link value for JAL/JALR.
REQ-011 SHALL have port fetch_valid, output, 1, high only in RUN; the instruction at pc is executed this cycle.
REQ-012 SHALL have port halted, output, 1, high in HALT.
REQ-013 SHALL have port misaligned_fault, output, 1, a sticky flag for a non-word-aligned jump or branch target.
REQ-014 SHALL have port retired_count, output, 32, the count of completed instructions.

Function
REQ-015 SHALL implement states BOOT, RUN and HALT, with BOOT entered on any cycle where rst=1.
REQ-016 BOOT SHALL hold pc=RESET_PC with fetch_valid=0 for exactly one cycle after rst deasserts, then move to RUN.
REQ-017 In RUN, each cycle SHALL resolve in priority order: stall, then halt_req, then misaligned target, then advance.
REQ-018 In RUN with stall=1, it SHALL hold pc, the state and retired_count; halt_req and the target check are ignored that cycle.
REQ-019 In RUN with stall=0 and halt_req=1, it SHALL go to HALT with pc unchanged, and retired_count SHALL increment, since the halting instruction counts.
REQ-020 In RUN with stall=0, halt_req=0 and a selected target with bits[1:0]!=2'b00, it SHALL go to HALT with pc unchanged, set misaligned_fault=1, and leave retired_count unchanged.
REQ-021 The alignment check SHALL apply to the final selected next PC; for JALR, bit0 is cleared before the check, so only bit1 can fault; PC+4 never faults.
REQ-022 Otherwise in RUN, pc SHALL load the selected next PC and retired_count SHALL increment by 1.
REQ-023 All address arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 gives 32'h0000_0000 with no fault.
REQ-024 retired_count SHALL wrap from 32'hFFFF_FFFF to 0 without a flag.
REQ-025 HALT SHALL be absorbing until rst: pc, retired_count and misaligned_fault are frozen, and all inputs are ignored.
REQ-026 The next-PC selection, pc_plus4 and the alignment check SHALL be combinational; only pc, the state, retired_count and misaligned_fault are registered.

Reset
REQ-027 While rst=1 at an edge, it SHALL set pc=RESET_PC, state=BOOT, retired_count=0 and misaligned_fault=0; therefore fetch_valid=0 and halted=0.
REQ-028 rst asserted mid-RUN or in HALT SHALL take effect at the next edge regardless of stall or halt_req.
REQ-029 The outputs SHALL be undefined-free after the first reset edge; there is no X on pc.

Verification
REQ-030 Reset, then 5 cycles with next_pc_src=00, SHALL give pc sequence 0 (BOOT), 0, 4, 8, 0xC, 0x10 and retired_count=4 at the pc=0x10 cycle.
REQ-031 At pc=0x8 with next_pc_src=01 and imm=0xFFFF_FFF8, the next pc SHALL be 0x0; at pc=0x10 with imm=0x10, the next pc SHALL be 0x20.
REQ-032 next_pc_src=10 with rs1_data=0x0000_0105 and imm=0x2 SHALL give target 0x106, so halted=1, misaligned_fault=1, pc unchanged and retired_count unchanged; rs1_data=0x0000_0103 with imm=0 SHALL give target 0x102, which also faults; rs1_data=0x0000_0021 with imm=0x3 SHALL give target 0x24, with no fault.
REQ-033 stall=1 for 3 cycles, with halt_req=1 and next_pc_src=01, SHALL hold pc and retired_count; releasing the stall with halt_req=1 SHALL give halted=1 and retired_count+1 at the next edge.
REQ-034 In HALT, toggling all inputs for 10 cycles SHALL leave the outputs frozen; rst=1 for one edge SHALL then restore pc=RESET_PC, retired_count=0, misaligned_fault=0 and fetch_valid=0.
REQ-035 With RESET_PC=32'hFFFF_FFFC and next_pc_src=00, pc SHALL go 0xFFFF_FFFC to 0x0 with no fault.
